// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the operand adder, the sum accumulator
// and its downstream consumer.
interface sum_accumulator_if #(
  parameter int DATA_IN_WIDTH = 8,
  parameter int NUM_SAMPLES   = 4
);
  localparam int IN_W  = DATA_IN_WIDTH + 1;
  localparam int SUM_W = IN_W + $clog2(NUM_SAMPLES);
  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);

  logic [IN_W-1:0]  in_sum;
  logic             in_valid;
  logic             in_ready;
  logic             flush_i;
  logic [SUM_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_sum, in_valid, flush_i, out_ready,
    input  in_ready, out_sum, out_count, out_valid
  );

  modport slave (
    input  in_sum, in_valid, flush_i, out_ready,
    output in_ready, out_sum, out_count, out_valid
  );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates NUM_SAMPLES adder sums into one widened total,
// with early flush and a registered valid/ready output.
module sum_accumulator #(
  parameter int DATA_IN_WIDTH = 8,
  parameter int NUM_SAMPLES   = 4
) (
  input logic              clk_i,
  input logic              srst,
  sum_accumulator_if.slave bus
);
  localparam int IN_W  = DATA_IN_WIDTH + 1;
  localparam int SUM_W = IN_W + $clog2(NUM_SAMPLES);
  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_SAMPLES);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state;
  logic [SUM_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [SUM_W-1:0] sum_q;
  logic [CNT_W-1:0] count_q;
  logic             valid_q;

  logic             in_hs;
  logic             out_hs;
  logic [SUM_W-1:0] in_ext;
  logic [SUM_W-1:0] a_next;
  logic [CNT_W-1:0] n_next;

  assign bus.in_ready  = (state == ACCUM) | bus.out_ready;
  assign bus.out_sum   = sum_q;
  assign bus.out_count = count_q;
  assign bus.out_valid = valid_q;

  assign in_hs  = bus.in_valid & bus.in_ready;
  assign out_hs = valid_q & bus.out_ready;
  assign in_ext = SUM_W'(bus.in_sum);
  assign a_next = acc + (in_hs ? in_ext : '0);
  assign n_next = cnt + CNT_W'(in_hs);

  always_ff @(posedge clk_i) begin
    if (srst) begin
      state   <= ACCUM;
      acc     <= '0;
      cnt     <= '0;
      sum_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (in_hs && n_next == FULL) begin
            sum_q   <= a_next;
            count_q <= FULL;
            valid_q <= 1'b1;
            acc     <= '0;
            cnt     <= '0;
            state   <= HOLD;
          end else if (bus.flush_i && n_next != '0) begin
            sum_q   <= a_next;
            count_q <= n_next;
            valid_q <= 1'b1;
            acc     <= '0;
            cnt     <= '0;
            state   <= HOLD;
          end else begin
            acc <= a_next;
            cnt <= n_next;
          end
        end
        HOLD: begin
          if (out_hs && in_hs) begin
            // A single-sample total completes on the same beat it starts.
            if (NUM_SAMPLES == 1) begin
              sum_q   <= in_ext;
              count_q <= ONE;
            end else begin
              acc     <= in_ext;
              cnt     <= ONE;
              valid_q <= 1'b0;
              state   <= ACCUM;
            end
          end else if (out_hs) begin
            valid_q <= 1'b0;
            state   <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream stage of the operand adder. Consumes its (DATA_IN_WIDTH+1)-bit sum stream over a valid/ready handshake.
- Accumulates NUM_SAMPLES accepted sums into one widened total and presents it on a registered valid/ready output.
- A flush input forces out a partial total early. Output carries the number of samples it contains.

Parameters:
- DATA_IN_WIDTH, 8, operand width of the upstream adder. Input sum width IN_W = DATA_IN_WIDTH+1.
- NUM_SAMPLES, 4, sums per total (>=1). SUM_W = IN_W + $clog2(NUM_SAMPLES). CNT_W = $clog2(NUM_SAMPLES+1).

Ports:
- clk_i  input  1  clock, all logic on rising edge
- srst  input  1  synchronous active-high reset; one clock; sampled on clk_i rising edge
- in_sum  input  IN_W  sum from upstream adder
- in_valid  input  1  in_sum valid
- in_ready  output  1  block accepts in_sum this cycle
- flush_i  input  1  emit current partial total (level, sampled each cycle)
- out_sum  output  SUM_W  accumulated total (registered)
- out_count  output  CNT_W  number of samples in out_sum (registered)
- out_valid  output  1  out_sum/out_count valid (registered)
- out_ready  input  1  downstream accepts output

Behaviour:
- Reset (srst=1 at edge): state=ACCUM, acc=0, cnt=0, out_sum=0, out_count=0, out_valid=0. srst overrides all other inputs. Reset mid-accumulation or mid-HOLD discards all data; no output is produced for it.
- Terms:
  - in_hs = in_valid & in_ready.
  - out_hs = out_valid & out_ready.
  - n_next = cnt + in_hs.
  - a_next = acc + (in_hs ? in_sum : 0), zero-extended to SUM_W; never overflows.
- in_ready is combinational:
  - ACCUM: 1.
  - HOLD: out_ready (a slot frees the same cycle).
- State ACCUM (out_valid=0):
  - On in_hs with n_next==NUM_SAMPLES: out_sum<=a_next, out_count<=NUM_SAMPLES, out_valid<=1, acc<=0, cnt<=0, go HOLD.
  - Else if flush_i and n_next>0: out_sum<=a_next, out_count<=n_next, out_valid<=1, acc<=0, cnt<=0, go HOLD. Flush counts a sample accepted in the same cycle.
  - Else if flush_i and n_next==0: ignored; no empty output is ever produced.
  - Else: acc<=a_next, cnt<=n_next.
- State HOLD (out_valid=1):
  - out_sum, out_count stable until out_hs.
  - flush_i ignored in HOLD.
  - On out_hs without in_hs: out_valid<=0, go ACCUM.
  - On out_hs with in_hs: new accumulation starts in the same cycle, acc<=in_sum, cnt<=1.
    - If NUM_SAMPLES==1, that sample completes immediately: out_sum<=in_sum, out_count<=1, stay HOLD, out_valid stays 1. This gives 1 total/cycle throughput.
    - Otherwise go ACCUM with out_valid<=0.
  - No out_hs: hold everything; in_ready=0.
- Latency: out_valid rises the cycle after the completing input handshake (or the flush).
- Throughput: NUM_SAMPLES accepted inputs per total. No bubble on the input side.
- Data invariance: in_sum is ignored when in_valid=0. No combinational path from in_* to out_*.

Test Plan:
- DATA_IN_WIDTH=8, NUM_SAMPLES=4, out_ready=1; send 10,20,30,40 back-to-back -> one cycle after 4th accept: out_valid=1, out_sum=100, out_count=4; next cycle out_valid=0.
- Max values: send 511 x4 -> out_sum=2044, out_count=4 (no wrap in 11 bits).
- Backpressure: out_ready=0 after total 100 pending -> in_ready=0, out_sum held 100 for 5 cycles. Raise out_ready with in_valid=1, in_sum=7 -> output accepted and 7 accepted same cycle. Next total includes 7 as first sample, cnt=1.
- Flush: send 5,6, then flush_i=1 with in_valid=1, in_sum=9 -> out_sum=20, out_count=3. Flush with cnt=0 and in_valid=0 -> no out_valid.
- Reset mid-op: accept 3 samples, assert srst one cycle -> out_valid=0, in_ready=1. Then 1,1,1,1 -> out_sum=4 (old data discarded).
- NUM_SAMPLES=1, out_ready=1, in_valid continuous 3,4,5 -> out_valid held 1, out_sum=3,4,5 on consecutive cycles, out_count=1.
